// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_pkg                                               |
// | Purpose : Shared UART constants and receiver state encoding.     |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int C_SIZE      = 8;
    localparam int C_BAUD_RATE = 115200;
    localparam int C_CLK_FREQ  = 1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx_if                                             |
// | Purpose : Serial line, consumer handshake and status of the RX.  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int SIZE = C_SIZE
) ();

    logic            rx;
    logic            rx_ack;
    logic [SIZE-1:0] data_out;
    logic            rx_valid;
    logic            rx_busy;
    logic            frame_err;
    logic            overrun_err;

    modport master (
        input  rx,
        input  rx_ack,
        output data_out,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output overrun_err
    );

    modport slave (
        output rx,
        output rx_ack,
        input  data_out,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  overrun_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_sync2                                             |
// | Purpose : Two-flop synchronizer with a selectable reset level.   |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_rx                                                |
// | Purpose : 8N1-style UART receiver, LSB first, mid-bit sampling.  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module uart_rx
    import uart_pkg::*;
#(
    parameter int SIZE       = C_SIZE,
    parameter int BAUD_RATE  = C_BAUD_RATE,
    parameter int CLK_FREQ   = C_CLK_FREQ,
    parameter int BAUD_COUNT = CLK_FREQ / BAUD_RATE
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    localparam int C_CW = (BAUD_COUNT > 1) ? $clog2(BAUD_COUNT) : 1;
    localparam int C_IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [C_CW-1:0] C_CNT_HALF = C_CW'(BAUD_COUNT / 2 - 1);
    localparam logic [C_CW-1:0] C_CNT_LAST = C_CW'(BAUD_COUNT - 1);
    localparam logic [C_CW-1:0] C_CNT_ONE  = C_CW'(1);
    localparam logic [C_IW-1:0] C_IDX_LAST = C_IW'(SIZE - 1);
    localparam logic [C_IW-1:0] C_IDX_ONE  = C_IW'(1);

    logic w_rx_s;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [C_CW-1:0] r_cnt;
    logic [C_CW-1:0] w_cnt_nxt;
    logic [C_IW-1:0] r_idx;
    logic [C_IW-1:0] w_idx_nxt;
    logic [SIZE-1:0] r_shift;
    logic [SIZE-1:0] w_shift_nxt;
    logic [SIZE-1:0] r_data;
    logic [SIZE-1:0] w_data_nxt;
    logic            r_valid;
    logic            w_valid_nxt;
    logic            r_ferr;
    logic            w_ferr_nxt;
    logic            r_ovr;
    logic            w_ovr_nxt;

    // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_ferr_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;

        if (bus.rx_ack) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!w_rx_s) begin
                    w_state_nxt = START;
                end
            end

            START: begin
                if (r_cnt == C_CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    // A line back high at mid-bit was a glitch, not a start bit.
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            DATA: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    if (r_idx == C_IDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_idx + C_IDX_ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            STOP: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (w_rx_s) begin
                        // A fresh load beats a same-cycle acknowledge.
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_ovr_nxt   = r_valid & ~bus.rx_ack;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    assign bus.data_out    = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.rx_busy     = (r_state != IDLE);
    assign bus.frame_err   = r_ferr;
    assign bus.overrun_err = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_uart_rx                                             |
// | Purpose : Directed, table-driven self-checking bench for uart_rx.|
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_uart_rx;

    localparam int C_BC = 8;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       pre_ack;
        logic [7:0] exp_d;
        logic       exp_v;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int   checks   = 0;
    int   passes   = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    int   rise_cyc = -1;
    int   ferr_cnt = 0;
    int   ovr_cnt  = 0;
    logic prev_v   = 1'b0;

    vec_t       vt[5];
    logic [7:0] got[2];
    int         f0;
    int         o0;
    int         w;

    always #5 clk = ~clk;

    uart_rx_if #(.SIZE(8)) ifc ();

    uart_rx #(
        .SIZE       (8),
        .BAUD_RATE  (115200),
        .CLK_FREQ   (1000000),
        .BAUD_COUNT (C_BC)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (ifc.master)
    );

    // Cycle counter, rx_valid rise time and pulse counters, sampled 1 unit after each edge.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (ifc.rx_valid && !prev_v) rise_cyc = cyc;
        prev_v = ifc.rx_valid;
        if (ifc.frame_err)   ferr_cnt = ferr_cnt + 1;
        if (ifc.overrun_err) ovr_cnt  = ovr_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act === exp) passes = passes + 1;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ifc.rx = b;
        repeat (C_BC) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        fall_cyc = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        ifc.rx = 1'b1;
    endtask

    task automatic ack_pulse();
        ifc.rx_ack = 1'b1;
        @(negedge clk);
        ifc.rx_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0, 1, 0};
        vt[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
        vt[2] = '{8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 0, 1};
        vt[3] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 0, 0};
        vt[4] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 0, 1};

        ifc.rx     = 1'b1;
        ifc.rx_ack = 1'b0;
        tick(3);
        check("rst_data",  ifc.data_out,    8'h00);
        check("rst_valid", ifc.rx_valid,    1'b0);
        check("rst_busy",  ifc.rx_busy,     1'b0);
        check("rst_ferr",  ifc.frame_err,   1'b0);
        check("rst_ovr",   ifc.overrun_err, 1'b0);
        rst_n = 1'b1;
        tick(4);

        // Frame 0xA5: 78 cycles from the first edge seeing rx low to rx_valid rising.
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1);
        tick(4);
        check("a5_latency", rise_cyc - fall_cyc, 78);
        check("a5_data",    ifc.data_out, 8'hA5);
        check("a5_valid",   ifc.rx_valid, 1'b1);
        check("a5_ferr",    ferr_cnt - f0, 0);

        // False start: two cycles low, aborted at the mid-bit check.
        ack_pulse();
        check("ack_clear", ifc.rx_valid, 1'b0);
        f0 = ferr_cnt;
        ifc.rx = 1'b0;
        tick(2);
        ifc.rx = 1'b1;
        tick(1);
        check("fs_busy_hi", ifc.rx_busy, 1'b1);
        tick(8);
        check("fs_busy_lo", ifc.rx_busy, 1'b0);
        check("fs_valid",   ifc.rx_valid, 1'b0);
        check("fs_data",    ifc.data_out, 8'hA5);
        check("fs_ferr",    ferr_cnt - f0, 0);

        for (int k = 0; k < 5; k++) begin
            if (vt[k].pre_ack) begin
                ack_pulse();
                check("tbl_preack", ifc.rx_valid, 1'b0);
            end
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            send_frame(vt[k].d, vt[k].stop);
            tick(16);
            check("tbl_data",  ifc.data_out,  vt[k].exp_d);
            check("tbl_valid", ifc.rx_valid,  vt[k].exp_v);
            check("tbl_ferr",  ferr_cnt - f0, vt[k].exp_ferr);
            check("tbl_ovr",   ovr_cnt - o0,  vt[k].exp_ovr);
            check("tbl_busy",  ifc.rx_busy,   1'b0);
        end

        // Back-to-back 0x11, 0x22 without acknowledge.
        ack_pulse();
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(4);
        check("b2b_ovr",   ovr_cnt - o0, 1);
        check("b2b_data",  ifc.data_out, 8'h22);
        check("b2b_valid", ifc.rx_valid, 1'b1);
        ack_pulse();
        check("b2b_ack", ifc.rx_valid, 1'b0);

        // Back-to-back 0x00, 0xFF, each acknowledged as it arrives.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    w = 0;
                    while (!ifc.rx_valid && w < 300) begin
                        @(negedge clk);
                        w = w + 1;
                    end
                    check("ack_wait", (w < 300), 1'b1);
                    got[k] = ifc.data_out;
                    ack_pulse();
                end
            end
        join
        tick(4);
        check("acked_d0",   got[0], 8'h00);
        check("acked_d1",   got[1], 8'hFF);
        check("acked_ovr",  ovr_cnt - o0,  0);
        check("acked_ferr", ferr_cnt - f0, 0);

        // Reset during data bit 4 of 0xFF, then a clean 0x00 frame.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        ifc.rx = 1'b0;
        tick(C_BC);
        ifc.rx = 1'b1;
        tick(4 * C_BC + C_BC / 2);
        check("mid_busy", ifc.rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_data",  ifc.data_out, 8'h00);
        check("mr_valid", ifc.rx_valid, 1'b0);
        check("mr_busy",  ifc.rx_busy,  1'b0);
        tick(3);
        check("mr_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);
        rst_n = 1'b1;
        tick(20);
        check("post_busy",  ifc.rx_busy,  1'b0);
        check("post_valid", ifc.rx_valid, 1'b0);
        send_frame(8'h00, 1'b1);
        tick(4);
        check("clean_data",  ifc.data_out, 8'h00);
        check("clean_valid", ifc.rx_valid, 1'b1);
        check("clean_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning line bit rate in bits/s.
REQ-003 SHALL have parameter CLK_FREQ, default 1000000, meaning clk frequency in Hz.
REQ-004 SHALL have parameter BAUD_COUNT, default CLK_FREQ/BAUD_RATE (=8), meaning clk cycles per bit; legal range 4..255.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, the reset; asynchronous and active-low (0 = reset).
REQ-007 SHALL have port rx, input, 1, the asynchronous serial line; idles high.
REQ-008 SHALL have port rx_ack, input, 1, consumer acknowledge; it clears rx_valid.
REQ-009 SHALL have port data_out, output, SIZE, the last good received byte.
REQ-010 SHALL have port rx_valid, output, 1, which is high while data_out holds unconsumed data.
REQ-011 SHALL have port rx_busy, output, 1, which is high while a frame is in progress.
REQ-012 SHALL have port frame_err, output, 1, a one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port overrun_err, output, 1, a one-cycle pulse when a good frame completes while rx_valid=1.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized signal rx_s.
REQ-015 SHALL implement FSM states IDLE, START, DATA and STOP, with a baud counter cnt of width clog2(BAUD_COUNT) and a bit index of width clog2(SIZE).
REQ-016 In IDLE, cnt=0, rx_busy=0; when rx_s=0, the FSM SHALL go to START on the next edge.
REQ-017 In START, on cnt==BAUD_COUNT/2-1 (mid-bit), the FSM SHALL check rx_s: if 0, go to DATA with cnt=0; if 1 (false start), go to IDLE with no flags; otherwise cnt increments.
REQ-018 In DATA, on cnt==BAUD_COUNT-1, the FSM SHALL shift rx_s into bit position [index] (LSB first) and reset cnt=0; after index SIZE-1 it goes to STOP, otherwise index increments.
REQ-019 In STOP, on cnt==BAUD_COUNT-1, the FSM SHALL sample rx_s and then return to IDLE.
REQ-020 If the STOP sample is 1, the block SHALL load data_out from the shift register and set rx_valid on the next edge.
REQ-021 If the STOP sample is 0, the block SHALL pulse frame_err for one cycle and leave data_out and rx_valid unchanged.
REQ-022 rx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-023 rx_valid SHALL clear on the edge after rx_ack=1; rx_ack while rx_valid=0 SHALL be ignored.
REQ-024 On good-stop completion with rx_valid=1 and no rx_ack that cycle, the block SHALL overwrite data_out, keep rx_valid=1 and pulse overrun_err.
REQ-025 If good-stop load and rx_ack coincide, the load SHALL win: rx_valid stays 1 and there is no overrun.
REQ-026 From the synchronized start edge to rx_valid rising, latency SHALL be BAUD_COUNT/2 + (SIZE+1)*BAUD_COUNT cycles, plus 2 cycles of synchronizer delay.
REQ-027 A new frame SHALL be accepted from IDLE on the cycle after STOP; there are no dead bit times between back-to-back frames.
REQ-028 The receiver SHALL NOT resynchronize mid-frame; edges inside DATA and STOP are ignored.

Reset
REQ-029 On rst=0, the block SHALL asynchronously set: state=IDLE, cnt=0, index=0, shift register=0, data_out=0, rx_valid=0, rx_busy=0, frame_err=0, overrun_err=0, and both synchronizer flops=1.
REQ-030 Reset mid-frame SHALL discard the partial byte with no flags; after release, the FSM SHALL wait for a fresh high-to-low edge.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP) and the default constants SIZE, BAUD_RATE and CLK_FREQ, shared with the transmitter.
REQ-032 The synchronizer SHALL be a sub-module, uart_sync2, with its reset value set to 1.

Verification
REQ-033 Frame 0xA5 at 8 clk/bit (start, 1,0,1,0,0,1,0,1, stop) -> data_out=0xA5; rx_valid rises 78 cycles after the rx fall; frame_err=0.
REQ-034 rx low for 2 cycles, then high -> START aborts at the mid-bit check; state returns to IDLE; rx_valid=0, frame_err=0.
REQ-035 Frame 0x3C with stop bit 0 -> frame_err pulses for exactly 1 cycle; data_out keeps its prior value; rx_valid=0.
REQ-036 Frames 0x11 then 0x22 back-to-back with no rx_ack -> overrun_err pulses once, data_out=0x22, rx_valid=1; rx_ack -> rx_valid=0 next edge.
REQ-037 rst=0 asserted during data bit 4 of 0xFF, then released, then frame 0x00 sent -> no output during reset; data_out=0x00, rx_valid=1 after the clean frame.
REQ-038 Frames 0x00 and 0xFF back-to-back, each acked when rx_valid rises -> both received correctly with no overrun_err or frame_err.
